mem_stage_port: RTL and testbench

Memory-stage data-memory port of the pipelined CPU. Consumes the registered memory-stage controls and data from the EX/MEM register. Runs a req/ack handshake with a variable-latency data memory and stalls the pipeline until the access completes. Presents load data to the MEM/WB register in the cycle the instruction leaves the memory stage.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_port.sv | 111 +++++++++++
 tb/tb_mem_stage_port.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_stage_pkg
// Brief   : Shared types and constants for the memory-stage data-memory port.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  // Port state: IDLE = nothing in flight, BUSY = request outstanding,
  // DONE = result presented, instruction leaves the stage this cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Default number of BUSY cycles tolerated without an ack.
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  // Width of the BUSY-cycle counter (saturating).
  localparam int unsigned CNT_W = 8;

  // Bit value replicated into rdata_out on stores and error completions.
  localparam logic ERR_FILL_BIT = 1'b0;

endpackage : mem_stage_pkg

`default_nettype wire

// File: rtl/mem_stage_port.sv
//------------------------------------------------------------------------------
// Module  : mem_stage_port
// Brief   : Memory-stage data-memory port. Issues a req/ack access to a
//           variable-latency data memory, stalls the pipeline until it
//           completes, and flags misaligned addresses and ack timeouts.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage_port
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              misalign,
  output logic              timeout,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] C_FILL    = {DATA_W{ERR_FILL_BIT}};

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic             w_access;
  logic             w_aligned;

  assign w_access  = mem_read | mem_write;
  assign w_aligned = (addr[1:0] == 2'b00);

  // Hold the front of the pipeline while an access is being started or is outstanding.
  assign stall = ~rst & (((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY));

  // FSM, BUSY-cycle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      rdata_out <= '0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses; they are only set on entry to DONE.
      misalign <= 1'b0;
      timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_aligned) begin
              dm_req   <= 1'b1;
              dm_we    <= mem_write;
              dm_addr  <= addr;
              dm_wdata <= wdata;
              r_count  <= '0;
              r_state  <= ST_BUSY;
            end else begin
              rdata_out <= C_FILL;
              misalign  <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (dm_ack) begin
            dm_req    <= 1'b0;
            rdata_out <= dm_we ? C_FILL : dm_rdata;
            r_state   <= ST_DONE;
          end else if (r_count == C_CNT_LAST) begin
            dm_req    <= 1'b0;
            rdata_out <= C_FILL;
            timeout   <= 1'b1;
            r_state   <= ST_DONE;
          end else if (r_count != C_CNT_MAX) begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_DONE: begin
          // EX/MEM still holds the finished instruction, so never re-issue here.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          dm_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule : mem_stage_port

`default_nettype wire

// File: tb/tb_mem_stage_port.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_stage_port
// Brief   : Self-checking bench for mem_stage_port; directed scenarios plus
//           randomized accesses compared against a transaction-level model.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage_port;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int          BUDGET  = 100;

  logic              clk;
  logic              rst;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stall;
  logic [DATA_W-1:0] rdata_out;
  logic              misalign;
  logic              timeout;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  int n_checks;
  int n_errors;

  mem_stage_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .rdata_out(rdata_out),
    .misalign (misalign),
    .timeout  (timeout),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Run one instruction through the stage. k = BUSY cycle in which the memory
  // acks (0 = never). Called at a negedge with the port idle; returns at a
  // negedge with the port idle again.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int k, input logic [31:0] rdv);
    logic acc, aligned, timed_out;
    int   exp_stall, exp_req, exp_rdata;
    int   n_stall, n_req, attr_bad, prev_req, n_rise;
    logic done;
    // Transaction-level expectation.
    acc       = rd | wr;
    aligned   = (a % 4) == 0;
    timed_out = acc && aligned && (k < 1 || k > int'(TIMEOUT));
    if (!acc)            exp_stall = 0;
    else if (!aligned)   exp_stall = 1;
    else if (timed_out)  exp_stall = TIMEOUT + 1;
    else                 exp_stall = k + 1;
    exp_req   = (acc && aligned) ? exp_stall - 1 : 0;
    exp_rdata = (acc && aligned && !wr && !timed_out) ? rdv : 0;

    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    n_stall = 0; n_req = 0; attr_bad = 0; prev_req = 0; n_rise = 0; done = 0;
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      #1;
      if (!stall) begin
        done = 1;
      end else begin
        n_stall++;
        if (dm_req) begin
          n_req++;
          if (!prev_req) n_rise++;
          if (dm_we !== wr || dm_addr !== a || dm_wdata !== wd) attr_bad++;
          if (n_req == k) begin
            dm_ack   = 1'b1;
            dm_rdata = rdv;
          end else begin
            dm_rdata = $urandom;
          end
        end
        prev_req = dm_req;
        @(posedge clk);
        @(negedge clk);
        dm_ack = 1'b0;
      end
    end
    chk("done_reached", {31'd0, done}, 32'd1);
    chk("stall_cycles", n_stall, exp_stall);
    chk("req_cycles", n_req, exp_req);
    if (acc) begin
      chk("req_attr_stable", attr_bad, 0);
      chk("req_count", n_rise, (acc && aligned) ? 1 : 0);
      chk("done_dm_req", {31'd0, dm_req}, 32'd0);
      chk("done_rdata", rdata_out, exp_rdata);
      chk("done_misalign", {31'd0, misalign}, {31'd0, ~aligned});
      chk("done_timeout", {31'd0, timeout}, {31'd0, timed_out});
    end
    @(posedge clk);
    #1;
    if (acc) begin
      chk("flag_clear", {30'd0, misalign, timeout}, 32'd0);
      chk("idle_dm_req", {31'd0, dm_req}, 32'd0);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    dm_ack    = 1'b0;
    dm_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_outputs", {27'd0, dm_req, dm_we, misalign, timeout, |rdata_out}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    // stall is held low while reset is asserted even with an access pending.
    mem_read = 1'b1;
    #1;
    chk("rst_forces_stall0", {31'd0, stall}, 32'd0);
    mem_read = 1'b0;
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    run_access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0);                 // non-memory
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hCAFE_F00D);         // load, k=1
    run_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'hDEAD_BEEF); // store, k=3
    run_access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h5555_AAAA);         // misaligned
    run_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h0);                 // timeout
    run_access(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_0001, 2, 32'h7777_7777); // both -> write
    run_access(1'b0, 1'b1, 32'h0000_0050, 32'h0BAD_F00D, 1, 32'h0);         // back-to-back
    run_access(1'b1, 1'b0, 32'h0000_0050, 32'h0, 1, 32'h0BAD_F00D);
    run_access(1'b1, 1'b0, 32'h0000_0060, 32'h0, TIMEOUT, 32'h1357_9BDF);   // ack on last cycle

    // Reset during the second BUSY cycle, then a late ack.
    mem_read = 1'b1;
    addr     = 32'h0000_0070;
    @(posedge clk);   // IDLE -> BUSY
    @(posedge clk);   // first BUSY cycle
    @(negedge clk);   // inside second BUSY cycle
    chk("pre_rst_req", {31'd0, dm_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    mem_read = 1'b0;
    #1;
    rst = 1'b0;
    chk("post_rst_req", {31'd0, dm_req}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    dm_ack   = 1'b1;
    dm_rdata = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    dm_ack = 1'b0;
    chk("late_ack_stall", {31'd0, stall}, 32'd0);
    chk("late_ack_outputs", {27'd0, dm_req, dm_we, misalign, timeout, |rdata_out}, 32'd0);
    chk("late_ack_addr", dm_addr, 32'd0);
    @(negedge clk);

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      logic r, w;
      logic [31:0] a;
      r = 1'($urandom);
      w = 1'($urandom);
      a = $urandom & 32'h0000_FFFF;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      lat = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 6));
      run_access(r, w, a, $urandom, lat, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_stage_port

`default_nettype wire
